// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    StLen0,
    StLen1,
    StData,
    StCheck,
    StFlush,
    StDone,
    StErr
  } state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned COUNT_W        = 16;

endpackage

// File: rtl/byte_packer.sv
// Packs a little-endian byte stream into 32-bit words; word_valid_o pulses
// combinationally on the byte that completes a word.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  lane_q, lane_d;
  logic [31:0] shift_q, shift_d;

  // Shift right so the first byte of a word ends up in [7:0].
  assign word_o       = {byte_i, shift_q[31:8]};
  assign word_valid_o = byte_valid_i && (lane_q == 2'(BYTES_PER_WORD - 1));

  always_comb begin
    lane_d  = lane_q;
    shift_d = shift_q;
    if (clear_i) begin
      lane_d  = '0;
      shift_d = '0;
    end else if (byte_valid_i) begin
      lane_d  = lane_q + 2'd1;
      shift_d = word_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lane_q  <= '0;
      shift_q <= '0;
    end else begin
      lane_q  <= lane_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Streams a length-prefixed byte image into instruction memory, holding the core in reset
// until the image is complete. Define LOADER_CHECKSUM_EN to require a trailing checksum byte.
module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              error
);

`ifdef LOADER_CHECKSUM_EN
  localparam state_e AfterPayload = StCheck;
`else
  localparam state_e AfterPayload = StFlush;
`endif

  state_e              state_q, state_d;
  logic [7:0]          len_lo_q, len_lo_d;
  logic [COUNT_W-1:0]  len_q, len_d;
  logic [COUNT_W-1:0]  idx_q, idx_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          sum_q, sum_d;
`endif

  logic               fire;
  logic               restart;
  logic               word_valid;
  logic [31:0]        word;
  logic [COUNT_W-1:0] count;

  assign in_ready = (state_q == StLen0) || (state_q == StLen1) ||
                    (state_q == StData) || (state_q == StCheck);
  assign fire     = in_valid && in_ready;
  assign restart  = start && ((state_q == StDone) || (state_q == StErr));
  assign count    = {in_data, len_lo_q};

  assign core_rst  = (state_q != StDone);
  assign done      = (state_q == StDone);
  assign error     = (state_q == StErr);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  byte_packer u_byte_packer (
    .clk_i        (CLK),
    .rst_i        (RST),
    .clear_i      (restart),
    .byte_valid_i (fire && (state_q == StData)),
    .byte_i       (in_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_comb begin
    state_d     = state_q;
    len_lo_d    = len_lo_q;
    len_d       = len_q;
    idx_d       = idx_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    unique case (state_q)
      StLen0: begin
        if (fire) begin
          len_lo_d = in_data;
          state_d  = StLen1;
        end
      end
      StLen1: begin
        if (fire) begin
          len_d = count;
          if (32'(count) > (32'd1 << ADDR_W)) begin
            state_d = StErr;
          end else if (count == '0) begin
            state_d = AfterPayload;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (fire) begin
`ifdef LOADER_CHECKSUM_EN
          sum_d = sum_q + in_data;
`endif
          if (word_valid) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = idx_q[ADDR_W-1:0];
            mem_wdata_d = word;
            idx_d       = idx_q + 1'b1;
            if (idx_q == len_q - 1'b1) begin
              state_d = AfterPayload;
            end
          end
        end
      end
      StCheck: begin
`ifdef LOADER_CHECKSUM_EN
        if (fire) begin
          state_d = (in_data == sum_q) ? StFlush : StErr;
        end
`else
        state_d = StErr;
`endif
      end
      StFlush: state_d = StDone;
      StDone, StErr: begin
        if (start) begin
          state_d = StLen0;
          idx_d   = '0;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      default: state_d = StLen0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StLen0;
      len_lo_q    <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: loads, zero count, oversize, backpressure, checksum, reset.
module tb_prog_loader;

  localparam int unsigned ADDR_W = 10;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_rst;
  logic              done;
  logic              error;

  int unsigned cmp_cnt = 0;
  int unsigned err_cnt = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [7:0]  frame_q[$];

  prog_loader #(.ADDR_W(ADDR_W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_rst  (core_rst),
    .done      (done),
    .error     (error)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (mem_we) begin
      wr_addr_q.push_back(32'(mem_addr));
      wr_data_q.push_back(mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      tick();
    end
    in_valid = 1'b0;
  endtask

  function automatic logic [7:0] payload_sum(input logic [7:0] f[$]);
    logic [7:0] s = 8'h00;
    for (int i = 2; i < f.size(); i++) s = s + f[i];
    return s;
  endfunction

  // Sends header+payload and, when the checksum is built in, a checksum byte xor'd with cs_flip.
  task automatic send_load(input logic [7:0] f[$], input int max_gap, input logic [7:0] cs_flip);
    for (int i = 0; i < f.size(); i++) begin
      send_byte(f[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(payload_sum(f) ^ cs_flip, 0);
`else
    if (cs_flip != 8'h00) $display("note: checksum flip ignored in this build");
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_core_rst"}, 32'(core_rst), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic check_two_word(input string tag);
    check({tag, "_nwr"}, wr_addr_q.size(), 32'd2);
    if (wr_addr_q.size() == 2) begin
      check({tag, "_addr0"}, wr_addr_q[0], 32'd0);
      check({tag, "_data0"}, wr_data_q[0], 32'h0000_0513);
      check({tag, "_addr1"}, wr_addr_q[1], 32'd1);
      check({tag, "_data1"}, wr_data_q[1], 32'h0000_006F);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    frame_q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    repeat (2) tick();
    RST = 1'b0;
    check_reset_state("reset");

    // Two-word load, no gaps; release lands two cycles after the final byte.
    wr_addr_q.delete(); wr_data_q.delete();
    send_load(frame_q, 0, 8'h00);
    check("flush_done", 32'(done), 32'd0);
    check("flush_core_rst", 32'(core_rst), 32'd1);
    tick();
    check("release_done", 32'(done), 32'd1);
    check("release_core_rst", 32'(core_rst), 32'd0);
    check("done_in_ready", 32'(in_ready), 32'd0);
    check("hold_addr", 32'(mem_addr), 32'd1);
    check("hold_wdata", mem_wdata, 32'h0000_006F);
    tick();
    check_two_word("load");

    pulse_start();
    check("restart_in_ready", 32'(in_ready), 32'd1);
    check("restart_core_rst", 32'(core_rst), 32'd1);
    check("restart_done", 32'(done), 32'd0);

    // Zero count.
    wr_addr_q.delete(); wr_data_q.delete();
    frame_q = '{8'h00, 8'h00};
    send_load(frame_q, 0, 8'h00);
    tick();
    check("zero_done", 32'(done), 32'd1);
    check("zero_core_rst", 32'(core_rst), 32'd0);
    check("zero_nwr", wr_addr_q.size(), 32'd0);

    // Oversize count 1025.
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    tick();
    check("over_error", 32'(error), 32'd1);
    check("over_in_ready", 32'(in_ready), 32'd0);
    check("over_core_rst", 32'(core_rst), 32'd1);
    check("over_nwr", wr_addr_q.size(), 32'd0);
    pulse_start();
    check("over_restart_in_ready", 32'(in_ready), 32'd1);
    check("over_restart_error", 32'(error), 32'd0);

    // Backpressure: random gaps must not change the writes.
    wr_addr_q.delete(); wr_data_q.delete();
    frame_q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    send_load(frame_q, 5, 8'h00);
    repeat (2) tick();
    check("bp_done", 32'(done), 32'd1);
    check_two_word("bp");
    pulse_start();

`ifdef LOADER_CHECKSUM_EN
    // Bad checksum aborts after the words are written.
    wr_addr_q.delete(); wr_data_q.delete();
    send_load(frame_q, 0, 8'h01);
    tick();
    check("cs_bad_error", 32'(error), 32'd1);
    check("cs_bad_core_rst", 32'(core_rst), 32'd1);
    check_two_word("cs_bad");
    pulse_start();
`endif

    // Reset after 6 bytes: first word already written, then the frame is dropped.
    wr_addr_q.delete(); wr_data_q.delete();
    for (int i = 0; i < 6; i++) send_byte(frame_q[i], 0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check_reset_state("midrst");
    repeat (3) tick();
    check("midrst_nwr", wr_addr_q.size(), 32'd1);

    wr_addr_q.delete(); wr_data_q.delete();
    frame_q = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_load(frame_q, 0, 8'h00);
    repeat (2) tick();
    check("fresh_done", 32'(done), 32'd1);
    check("fresh_nwr", wr_addr_q.size(), 32'd1);
    if (wr_addr_q.size() == 1) begin
      check("fresh_addr", wr_addr_q[0], 32'd0);
      check("fresh_data", wr_data_q[0], 32'hDDCC_BBAA);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
